next_pc: RTL and testbench
==========================

# next_pc

Next-program-counter selector for the five-stage MIPS pipeline front end. It receives the fetch-stage PC plus branch, jump and register-jump operands decoded in ID. It produces the PC to load into the fetch PC register on the next cycle. The fetch stage applies its own overrides outside this block: exception-handler vector, ERET/EPC and freeze.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge active.
- reset  in  1  synchronous, active-high; sampled only on rising clk edge.
- oldPC  in  32  current fetch-stage PC, which is the delay-slot address when a control instruction sits in ID.
- imm32  in  32  sign-extended 16-bit branch offset in words, not pre-shifted.
- addr26  in  26  J/JAL instruction index field.
- ra32  in  32  forwarded rs register value for JR/JALR.
- PC_mux  in  2  next-PC source select: 00 sequential, 01 branch, 10 jump, 11 register.
- newPC  out  32  selected next PC.
- redirect  out  1  high when PC_mux != 00.
- misaligned  out  1  high when the selected target has bits [1:0] != 00.

## Operation
- Sequential (00): newPC = oldPC + 4.
- Branch (01): newPC = oldPC + (imm32 << 2). Shift discards imm32[31:30]. Sum is 32-bit modulo 2^32, so negative offsets subtract.
- Jump (10): newPC = {oldPC[31:28], addr26, 2'b00}. The region bits come from oldPC, the delay-slot PC.
- Register (11): newPC = ra32, passed unmodified. No alignment forcing.
- redirect = (PC_mux != 2'b00).
- misaligned = (selected_target[1:0] != 2'b00). Only mode 11 can raise it when oldPC is word-aligned; modes 00/01/10 preserve oldPC[1:0], or force it to 00 in mode 10.
- All additions wrap silently. No overflow flag. 0xFFFFFFFC + 4 = 0x00000000.
- The block does not range-check against instruction memory bounds. The fetch stage owns the PC exception.

## Timing
- Core selection is purely combinational from all data inputs and PC_mux.
- Output timing depends on NEXTPC_REG_OUT_EN (see Configuration).
- Registered mode:
  - Each rising clk edge captures newPC, redirect and misaligned.
  - If reset=1 at the edge: newPC=0x00003000, redirect=0, misaligned=0.
  - Reset mid-operation discards the pending selection. The first non-reset edge loads the normal selection.
- Combinational mode: no reset value. Outputs track inputs within the same cycle, and clk/reset are ignored.
- No handshake. Every cycle produces a valid result.

## Configuration
- NEXTPC_REG_OUT_EN defined: the three outputs are registered as described in Timing, with 1-cycle latency and reset values 0x00003000/0/0.
- NEXTPC_REG_OUT_EN undefined (default, used by the pipeline): outputs are combinational with 0-cycle latency. clk and reset remain ports but are unused.

## Test plan
- oldPC=0x00003004, PC_mux=00 -> newPC=0x00003008, redirect=0, misaligned=0.
- oldPC=0x00003008, imm32=0xFFFFFFFE, PC_mux=01 -> newPC=0x00003000, redirect=1.
  - Same oldPC with imm32=0x00000003 -> newPC=0x00003014.
- oldPC=0x00003010, addr26=0x0000C20, PC_mux=10 -> newPC=0x00003080.
  - oldPC=0xA0000000, addr26=0x3FFFFFF -> newPC=0xAFFFFFFC.
- PC_mux=11:
  - ra32=0x00004180 -> newPC=0x00004180, misaligned=0.
  - ra32=0x00003002 -> newPC=0x00003002, misaligned=1.
- Wrap: oldPC=0xFFFFFFFC, PC_mux=00 -> newPC=0x00000000.
  - Branch from oldPC=0x00000000 with imm32=0xFFFFFFFF -> newPC=0xFFFFFFFC.
- With NEXTPC_REG_OUT_EN:
  - Assert reset for 2 edges -> newPC=0x00003000, redirect=0.
  - Release reset with PC_mux=00, oldPC=0x00003000 -> newPC=0x00003004 one edge later.
  - Reasserting reset mid-sequence returns the outputs to reset values on the next edge.

Source files
------------

// File: rtl/next_pc.sv
// next_pc -- next-program-counter selector for the MIPS pipeline front end.
//
// Chooses between the sequential, branch, jump and register targets using
// PC_mux. It also flags a redirect (any non-sequential source) and a
// misaligned target (bits [1:0] not zero).
//
// Build option: define NEXTPC_REG_OUT_EN to register the three outputs. The
// registered build has one cycle of latency and synchronous reset values of
// 0x00003000/0/0. By default the outputs are combinational, and clk/reset
// are present but unused.

module next_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] oldPC,
  input  logic [31:0] imm32,
  input  logic [25:0] addr26,
  input  logic [31:0] ra32,
  input  logic [1:0]  PC_mux,
  output logic [31:0] newPC,
  output logic        redirect,
  output logic        misaligned
);

  localparam logic [1:0]  SEL_SEQ    = 2'b00;
  localparam logic [1:0]  SEL_BRANCH = 2'b01;
  localparam logic [1:0]  SEL_JUMP   = 2'b10;
  localparam logic [1:0]  SEL_REG    = 2'b11;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;

  // A target is misaligned when it does not fall on a word boundary.
  function automatic logic word_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  logic [31:0] seq_target_s;
  logic [31:0] branch_target_s;
  logic [31:0] jump_target_s;
  logic [31:0] sel_target_s;
  logic        sel_redirect_s;
  logic        sel_misaligned_s;

  // The word offset is shifted left by two, so imm32[31:30] fall off the top.
  // They are gathered here so that dropping them is visibly intentional.
  logic        unused_imm_hi_s;
  assign unused_imm_hi_s = ^imm32[31:30];

  // The candidate targets. Every addition wraps modulo 2^32, and the jump
  // target takes its region bits from the delay-slot PC.
  assign seq_target_s    = oldPC + 32'd4;
  assign branch_target_s = oldPC + {imm32[29:0], 2'b00};
  assign jump_target_s   = {oldPC[31:28], addr26, 2'b00};

  // Select the target and derive the status flags from it.
  always_comb begin
    sel_target_s   = seq_target_s;
    sel_redirect_s = 1'b0;
    case (PC_mux)
      SEL_SEQ: begin
        sel_target_s   = seq_target_s;
        sel_redirect_s = 1'b0;
      end
      SEL_BRANCH: begin
        sel_target_s   = branch_target_s;
        sel_redirect_s = 1'b1;
      end
      SEL_JUMP: begin
        sel_target_s   = jump_target_s;
        sel_redirect_s = 1'b1;
      end
      SEL_REG: begin
        sel_target_s   = ra32;
        sel_redirect_s = 1'b1;
      end
      default: begin
        sel_target_s   = seq_target_s;
        sel_redirect_s = 1'b0;
      end
    endcase
    sel_misaligned_s = word_misaligned(sel_target_s);
  end

`ifdef NEXTPC_REG_OUT_EN
  logic [31:0] new_pc_r;
  logic        redirect_r;
  logic        misaligned_r;

  // Output register. Reset discards whatever selection is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_pc_r     <= RESET_PC;
      redirect_r   <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      new_pc_r     <= sel_target_s;
      redirect_r   <= sel_redirect_s;
      misaligned_r <= sel_misaligned_s;
    end
  end

  assign newPC      = new_pc_r;
  assign redirect   = redirect_r;
  assign misaligned = misaligned_r;
`else
  // The combinational build ignores clk and reset; they stay as ports so
  // both builds share one interface.
  logic unused_clk_rst_s;
  assign unused_clk_rst_s = clk ^ reset ^ (RESET_PC[0]);

  assign newPC      = sel_target_s;
  assign redirect   = sel_redirect_s;
  assign misaligned = sel_misaligned_s;
`endif

endmodule

// File: tb/tb_next_pc.sv
// Self-checking bench for next_pc. It handles both builds: with
// NEXTPC_REG_OUT_EN it samples results one edge after the inputs are
// applied, and without it it samples after a short settle delay.

module tb_next_pc;

  logic        clk;
  logic        reset;
  logic [31:0] oldPC;
  logic [31:0] imm32;
  logic [25:0] addr26;
  logic [31:0] ra32;
  logic [1:0]  PC_mux;
  logic [31:0] newPC;
  logic        redirect;
  logic        misaligned;

  int total;
  int bad;

  next_pc dut (
    .clk        (clk),
    .reset      (reset),
    .oldPC      (oldPC),
    .imm32      (imm32),
    .addr26     (addr26),
    .ra32       (ra32),
    .PC_mux     (PC_mux),
    .newPC      (newPC),
    .redirect   (redirect),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: the architectural definition of each source.
  function automatic logic [31:0] ref_target(input logic [1:0] mode, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic [25:0] idx,
                                             input logic [31:0] rs);
    logic [31:0] region;
    logic [31:0] offs;
    case (mode)
      2'd0: return pc + 32'd4;
      2'd1: begin
        offs = imm * 32'd4;
        return pc + offs;
      end
      2'd2: begin
        region = pc & 32'hF000_0000;
        offs   = {6'd0, idx} * 32'd4;
        return region | offs;
      end
      default: return rs;
    endcase
  endfunction

  // Apply one set of inputs, wait for the result, then compare all outputs.
  task automatic apply_and_check(input string tag, input logic [1:0] mode,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [25:0] idx, input logic [31:0] rs);
    logic [31:0] exp_pc;
    exp_pc = ref_target(mode, pc, imm, idx, rs);
    oldPC  = pc;
    imm32  = imm;
    addr26 = idx;
    ra32   = rs;
    PC_mux = mode;
`ifdef NEXTPC_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check_val({tag, ".newPC"}, newPC, exp_pc);
    check_val({tag, ".redirect"}, {31'd0, redirect}, {31'd0, (mode != 2'd0)});
    check_val({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, ((exp_pc % 32'd4) != 32'd0)});
  endtask

  initial begin
    logic [1:0]  r_mode;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [25:0] r_idx;
    logic [31:0] r_rs;
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    oldPC  = 32'h0000_1234;
    imm32  = 32'd0;
    addr26 = 26'd0;
    ra32   = 32'h0000_0001;
    PC_mux = 2'b11;

`ifdef NEXTPC_REG_OUT_EN
    // Hold reset for two edges; the pending register selection must be lost.
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("rst.newPC", newPC, 32'h0000_3000);
    check_val("rst.redirect", {31'd0, redirect}, 32'd0);
    check_val("rst.misaligned", {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply_and_check("rel", 2'b00, 32'h0000_3000, 32'd0, 26'd0, 32'd0);
`else
    reset = 1'b0;
`endif

    // Directed cases.
    apply_and_check("seq",      2'b00, 32'h0000_3004, 32'd0,         26'd0,         32'd0);
    apply_and_check("br_neg",   2'b01, 32'h0000_3008, 32'hFFFF_FFFE, 26'd0,         32'd0);
    apply_and_check("br_pos",   2'b01, 32'h0000_3008, 32'h0000_0003, 26'd0,         32'd0);
    apply_and_check("jmp",      2'b10, 32'h0000_3010, 32'd0,         26'h000_0C20,  32'd0);
    apply_and_check("jmp_reg",  2'b10, 32'hA000_0000, 32'd0,         26'h3FF_FFFF,  32'd0);
    apply_and_check("jr_ok",    2'b11, 32'h0000_3000, 32'd0,         26'd0,         32'h0000_4180);
    apply_and_check("jr_mis",   2'b11, 32'h0000_3000, 32'd0,         26'd0,         32'h0000_3002);
    apply_and_check("seq_wrap", 2'b00, 32'hFFFF_FFFC, 32'd0,         26'd0,         32'd0);
    apply_and_check("br_wrap",  2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 26'd0,         32'd0);
    apply_and_check("br_hi",    2'b01, 32'h0000_1000, 32'hC000_0001, 26'd0,         32'd0);

    // Spot-check the literal values from the plan against constants too.
    apply_and_check("lit", 2'b01, 32'h0000_3008, 32'hFFFF_FFFE, 26'd0, 32'd0);
    check_val("lit.const", newPC, 32'h0000_3000);

`ifdef NEXTPC_REG_OUT_EN
    // Reassert reset in the middle of a sequence.
    @(negedge clk);
    reset  = 1'b1;
    PC_mux = 2'b11;
    ra32   = 32'h0000_5557;
    @(posedge clk);
    #1;
    check_val("mid_rst.newPC", newPC, 32'h0000_3000);
    check_val("mid_rst.redirect", {31'd0, redirect}, 32'd0);
    check_val("mid_rst.misaligned", {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply_and_check("post_rst", 2'b11, 32'h0000_3000, 32'd0, 26'd0, 32'h0000_5557);
`endif

    // Randomized vectors.
    for (int i = 0; i < 400; i++) begin
      r_mode = 2'($urandom_range(0, 3));
      r_pc   = $urandom;
      if ($urandom_range(0, 1) == 0) r_pc[1:0] = 2'b00;
      r_imm  = $urandom;
      if ($urandom_range(0, 1) == 0) r_imm = {{16{r_imm[15]}}, r_imm[15:0]};
      r_idx  = 26'($urandom);
      r_rs   = $urandom;
      if ($urandom_range(0, 1) == 0) r_rs[1:0] = 2'b00;
`ifdef NEXTPC_REG_OUT_EN
      @(negedge clk);
`endif
      apply_and_check("rand", r_mode, r_pc, r_imm, r_idx, r_rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
